// File: rtl/decode_sequencer.sv
// Phase-sequencing control decoder: FETCH/EXEC1/EXEC2/HALT FSM with a latched instruction.
// Define DECODE_STACK_GUARD_EN to mask stack strobes on full/empty and record a sticky stack_err.
module decode_sequencer #(
    parameter int INSTR_W  = 16,
    parameter int NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_valid,
    input  logic                stall,
    input  logic                eq,
    input  logic                stack_full,
    input  logic                stack_empty,
    output logic                fe,
    output logic                e1,
    output logic                e2,
    output logic                instr_rden,
    output logic                pc_cnten,
    output logic                pc_sload,
    output logic                data_wren,
    output logic [NUM_REGS-1:0] reg_wren,
    output logic                push_en,
    output logic                pop_en,
    output logic                halted,
    output logic                stack_err
);
    localparam int RSW = $clog2(NUM_REGS);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC1 = 2'd1;
    localparam logic [1:0] ST_EXEC2 = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [4:0] OP_STP = 5'b00000;
    localparam logic [4:0] OP_ADR = 5'b00001;
    localparam logic [4:0] OP_ADM = 5'b00011;
    localparam logic [4:0] OP_MLR = 5'b01001;
    localparam logic [4:0] OP_LDI = 5'b10000;
    localparam logic [4:0] OP_STA = 5'b10100;
    localparam logic [4:0] OP_LDA = 5'b11000;
    localparam logic [4:0] OP_STK = 5'b01101;
    localparam logic [4:0] OP_JMP = 5'b11101;
    localparam logic [4:0] OP_JEQ = 5'b11110;
    localparam logic [4:0] OP_JNQ = 5'b11111;

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               stack_err_q, stack_err_d;

    logic [4:0]     op;
    logic [RSW-1:0] d_field;
    logic           s_bit;
    logic           push_req, pop_req;
    logic           push_ok, pop_ok, guard_viol;
    logic           reg_write;
    logic           unused_instr_bits;

    assign op       = instr_q[INSTR_W-1 -: 5];
    assign d_field  = instr_q[INSTR_W-6 -: RSW];
    assign s_bit    = instr_q[0];
    assign push_req = (op == OP_STK) & ~s_bit;
    assign pop_req  = (op == OP_STK) & s_bit;
    assign unused_instr_bits = ^instr_q;

`ifdef DECODE_STACK_GUARD_EN
    assign push_ok    = push_req & ~stack_full;
    assign pop_ok     = pop_req & ~stack_empty;
    assign guard_viol = (push_req & stack_full) | (pop_req & stack_empty);
`else
    logic unused_stack_status;
    assign unused_stack_status = stack_full ^ stack_empty;
    assign push_ok    = push_req;
    assign pop_ok     = pop_req;
    assign guard_viol = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        stack_err_d = stack_err_q;
        fe          = 1'b0;
        e1          = 1'b0;
        e2          = 1'b0;
        instr_rden  = 1'b0;
        pc_cnten    = 1'b0;
        pc_sload    = 1'b0;
        data_wren   = 1'b0;
        push_en     = 1'b0;
        pop_en      = 1'b0;
        halted      = 1'b0;
        reg_write   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                fe = 1'b1;
                if (!stall) begin
                    instr_rden = 1'b1;
                    if (instr_valid) begin
                        pc_cnten = 1'b1;
                        instr_d  = instr;
                        state_d  = ST_EXEC1;
                    end
                end
            end
            ST_EXEC1: begin
                e1 = 1'b1;
                // Phase indicator stays up while stalled, every strobe is held low.
                if (!stall) begin
                    case (op)
                        OP_STP:                 state_d = ST_HALT;
                        OP_ADM, OP_MLR, OP_LDA: state_d = ST_EXEC2;
                        default:                state_d = ST_FETCH;
                    endcase
                    pc_sload    = (op == OP_JMP) | ((op == OP_JEQ) & eq) | ((op == OP_JNQ) & ~eq);
                    data_wren   = (op == OP_STA);
                    push_en     = push_ok;
                    pop_en      = pop_ok;
                    reg_write   = (op == OP_ADR) | (op == OP_LDI) | pop_ok;
                    stack_err_d = stack_err_q | guard_viol;
                end
            end
            ST_EXEC2: begin
                e2 = 1'b1;
                if (!stall) begin
                    reg_write = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_wren
            assign reg_wren[gi] = reg_write & (d_field == RSW'(gi));
        end
    endgenerate

    assign stack_err = stack_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            instr_q     <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            stack_err_q <= stack_err_d;
        end
    end
endmodule

// File: tb/tb_decode_sequencer.sv
module tb_decode_sequencer;
    localparam int INSTR_W  = 16;
    localparam int NUM_REGS = 4;

`ifdef DECODE_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam logic [4:0] OP_STP = 5'b00000;
    localparam logic [4:0] OP_ADR = 5'b00001;
    localparam logic [4:0] OP_ADM = 5'b00011;
    localparam logic [4:0] OP_MLR = 5'b01001;
    localparam logic [4:0] OP_LDI = 5'b10000;
    localparam logic [4:0] OP_STA = 5'b10100;
    localparam logic [4:0] OP_LDA = 5'b11000;
    localparam logic [4:0] OP_STK = 5'b01101;
    localparam logic [4:0] OP_JMP = 5'b11101;
    localparam logic [4:0] OP_JEQ = 5'b11110;
    localparam logic [4:0] OP_JNQ = 5'b11111;

    typedef struct packed {
        logic                fe;
        logic                e1;
        logic                e2;
        logic                rden;
        logic                cnt;
        logic                sload;
        logic                dwr;
        logic [NUM_REGS-1:0] rwr;
        logic                push;
        logic                pop;
        logic                halt;
        logic                serr;
    } out_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [INSTR_W-1:0] instr = '0;
    logic               instr_valid = 1'b0;
    logic               stall = 1'b0;
    logic               eq = 1'b0;
    logic               stack_full = 1'b0;
    logic               stack_empty = 1'b0;
    logic               fe, e1, e2, instr_rden, pc_cnten, pc_sload, data_wren;
    logic [NUM_REGS-1:0] reg_wren;
    logic               push_en, pop_en, halted, stack_err;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    serr_m = 1'b0;

    decode_sequencer #(.INSTR_W(INSTR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .eq(eq), .stack_full(stack_full), .stack_empty(stack_empty),
        .fe(fe), .e1(e1), .e2(e2), .instr_rden(instr_rden), .pc_cnten(pc_cnten),
        .pc_sload(pc_sload), .data_wren(data_wren), .reg_wren(reg_wren),
        .push_en(push_en), .pop_en(pop_en), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    out_t  mon_exp, mon_act;
    string mon_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {fe, e1, e2, instr_rden, pc_cnten, pc_sload, data_wren,
                        reg_wren, push_en, pop_en, halted, stack_err};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got=%h exp=%h", mon_name, mon_act, mon_exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t base();
        out_t o;
        o      = '0;
        o.serr = serr_m;
        return o;
    endfunction

    function automatic logic [INSTR_W-1:0] make_word(input logic [4:0] op, input int d, input bit s);
        logic [INSTR_W-1:0] w;
        w = INSTR_W'($urandom);
        w[INSTR_W-1 -: 5] = op;
        w[INSTR_W-6 -: 2] = 2'(d);
        w[0] = s;
        return w;
    endfunction

    task automatic step(input string nm, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [INSTR_W-1:0] w);
        int   n;
        out_t o;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            stall       = 1'($urandom_range(0, 1));
            instr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            instr       = INSTR_W'($urandom);
            o = base(); o.fe = 1'b1; o.rden = ~stall;
            step("fetch_wait", o);
        end
        stall = 1'b0; instr_valid = 1'b1; instr = w;
        o = base(); o.fe = 1'b1; o.rden = 1'b1; o.cnt = 1'b1;
        step("fetch", o);
        instr_valid = 1'b0;
        instr       = INSTR_W'($urandom);
    endtask

    task automatic exec_stalls(input int n, input bit second);
        out_t o;
        for (int i = 0; i < n; i++) begin
            stall       = 1'b1;
            eq          = 1'($urandom_range(0, 1));
            stack_full  = 1'($urandom_range(0, 1));
            stack_empty = 1'($urandom_range(0, 1));
            instr_valid = 1'($urandom_range(0, 1));
            o = base();
            if (second) o.e2 = 1'b1; else o.e1 = 1'b1;
            step(second ? "exec2_stall" : "exec1_stall", o);
        end
        stall = 1'b0;
    endtask

    task automatic run_instr(input logic [4:0] op, input int d, input bit s, input bit eqv,
                             input bit full, input bit empty, input int n1);
        out_t                o;
        logic [NUM_REGS-1:0] oh;
        bit                  push_ok, pop_ok, viol;
        $display("instr op=%b d=%0d s=%0d eq=%0d full=%0d empty=%0d stalls=%0d",
                 op, d, s, eqv, full, empty, n1);
        do_fetch(make_word(op, d, s));
        exec_stalls(n1, 1'b0);
        eq = eqv; stack_full = full; stack_empty = empty;
        instr_valid = 1'($urandom_range(0, 1));
        oh = '0; oh[d] = 1'b1;
        push_ok = (op == OP_STK) && !s && !(GUARD && full);
        pop_ok  = (op == OP_STK) && s && !(GUARD && empty);
        viol    = GUARD && (op == OP_STK) && (s ? empty : full);
        o = base(); o.e1 = 1'b1;
        o.sload = (op == OP_JMP) || (op == OP_JEQ && eqv) || (op == OP_JNQ && !eqv);
        o.dwr   = (op == OP_STA);
        o.push  = push_ok;
        o.pop   = pop_ok;
        if (op == OP_ADR || op == OP_LDI || pop_ok) o.rwr = oh;
        step("exec1", o);
        if (viol) serr_m = 1'b1;
        if (op == OP_ADM || op == OP_MLR || op == OP_LDA) begin
            exec_stalls($urandom_range(0, 2), 1'b1);
            o = base(); o.e2 = 1'b1; o.rwr = oh;
            step("exec2", o);
        end
    endtask

    initial begin
        out_t                o;
        logic [NUM_REGS-1:0] oh;
        logic [4:0]          rop;
        logic [4:0]          op_tab [10];
        op_tab = '{OP_ADR, OP_ADM, OP_MLR, OP_LDI, OP_STA, OP_LDA, OP_STK, OP_JMP, OP_JEQ, OP_JNQ};

        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            o = base(); o.fe = 1'b1; o.rden = 1'b1;
            step("reset", o);
        end
        reset = 1'b0;

        run_instr(OP_ADR, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(OP_LDA, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(OP_JEQ, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_instr(OP_JEQ, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(OP_JNQ, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(OP_STA, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run_instr(OP_STK, 1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        run_instr(OP_ADR, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("instr op=%b d=3 reset_in_exec2", OP_LDA);
        do_fetch(make_word(OP_LDA, 3, 1'b0));
        o = base(); o.e1 = 1'b1;
        step("exec1", o);
        reset = 1'b1;
        oh = '0; oh[3] = 1'b1;
        o = base(); o.e2 = 1'b1; o.rwr = oh;
        step("exec2_reset", o);
        serr_m = 1'b0;
        reset = 1'b0; instr_valid = 1'b0;
        #1;
        checks++;
        if (fe !== 1'b1 || reg_wren !== '0 || data_wren !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_direct: fe=%b reg_wren=%b data_wren=%b", fe, reg_wren, data_wren);
        end
        o = base(); o.fe = 1'b1; o.rden = 1'b1;
        step("post_reset_fetch", o);

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                rop = 5'($urandom);
                if (rop == OP_STP) rop = OP_ADR;
            end else begin
                rop = op_tab[$urandom_range(0, 9)];
            end
            run_instr(rop, $urandom_range(0, NUM_REGS - 1), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2));
        end

        run_instr(OP_STP, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 2));
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1'b1;
            stall       = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (halted !== 1'b1 || fe !== 1'b0 || e1 !== 1'b0 || e2 !== 1'b0 ||
                instr_rden !== 1'b0 || pc_cnten !== 1'b0 || reg_wren !== '0) begin
                errors++;
                $display("FAIL halt_direct: halted=%b fe=%b e1=%b e2=%b rden=%b cnt=%b rwr=%b",
                         halted, fe, e1, e2, instr_rden, pc_cnten, reg_wren);
            end
            o = base(); o.halt = 1'b1;
            step("halt", o);
        end
        stall = 1'b0; reset = 1'b1;
        o = base(); o.halt = 1'b1;
        step("halt_reset", o);
        serr_m = 1'b0;
        reset = 1'b0; instr_valid = 1'b0;
        #1;
        checks++;
        if (fe !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL after_halt_reset_direct: fe=%b halted=%b", fe, halted);
        end
        o = base(); o.fe = 1'b1; o.rden = 1'b1;
        step("after_halt_reset", o);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Parametrised successor to the CPU's combinational control decoder.
- Owns the FETCH/EXEC1/EXEC2 phase state machine internally instead of taking phase strobes as inputs.
- Decodes a generic-width instruction, drives the PC, data-memory, register-file and stack controls, and supports a stall input and a halt state.
- Register count is parametrised; register write enables are produced one-hot.

Parameters:
- INSTR_W, 16, instruction width in bits; legal range 8..32.
- NUM_REGS, 4, number of general registers; power of two, 2..16. Derived localparam RSW = clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  INSTR_W  instruction word. Sampled when entering EXEC1.
- instr_valid  in  1  instr is valid during FETCH.
- stall  in  1  freeze sequencer this cycle.
- eq  in  1  ALU equal flag.
- stack_full  in  1  stack full status.
- stack_empty  in  1  stack empty status.
- fe, e1, e2  out  1 each  one-hot phase indicators.
- instr_rden  out  1  instruction memory read enable.
- pc_cnten  out  1  PC increment enable.
- pc_sload  out  1  PC load enable (jump taken).
- data_wren  out  1  data memory write enable.
- reg_wren  out  NUM_REGS  one-hot register write enable.
- push_en, pop_en  out  1 each  stack push/pop strobes.
- halted  out  1  sequencer is in HALT.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Field definitions:
  - OP = instr[INSTR_W-1 -: 5].
  - D = instr[INSTR_W-6 -: RSW] (destination register).
  - S = instr[0] (0 = push, 1 = pop; STK only).
- Instruction latch: instr is latched into an internal register on the FETCH->EXEC1 transition. All decoding uses the latched copy.
- Opcodes:
  - 00000 STP.
  - 00001 ADR: 1-cycle, writes D in EXEC1.
  - 00011 ADM: 2-cycle, writes D in EXEC2.
  - 01001 MLR: 2-cycle, writes D in EXEC2.
  - 10000 LDI: writes D in EXEC1.
  - 10100 STA: data_wren in EXEC1.
  - 11000 LDA: 2-cycle, writes D in EXEC2.
  - 01101 STK: push or pop per S.
  - 11101 JMP.
  - 11110 JEQ.
  - 11111 JNQ.
  - All other opcodes are 1-cycle NOPs.
- States: FETCH, EXEC1, EXEC2, HALT. Reset forces FETCH and clears the latched instruction, stack_err and all outputs except fe/instr_rden.
- FETCH:
  - fe=1, instr_rden=1.
  - pc_cnten=1 only when instr_valid & ~stall.
  - Go to EXEC1 when instr_valid & ~stall; otherwise remain in FETCH.
- EXEC1:
  - e1=1.
  - STP -> HALT.
  - ADM/MLR/LDA -> EXEC2.
  - All other opcodes -> FETCH.
  - pc_sload = JMP | (JEQ & eq) | (JNQ & ~eq).
  - reg_wren[D]=1 for ADR, LDI, and for POP when the pop is permitted.
  - push_en = STK & ~S; pop_en = STK & S, subject to the guard rules under Optional Feature.
- EXEC2: e2=1; reg_wren[D]=1; next state is FETCH.
- HALT: halted=1. All strobes are 0. The state is left only by reset.
- Stall:
  - When stall=1, state and latch hold.
  - Every strobe is 0: instr_rden, pc_cnten, pc_sload, data_wren, reg_wren, push_en, pop_en.
  - The phase indicators fe/e1/e2 still show the current state.
- Output timing: strobes are combinational from state, latch and inputs. The phase outputs are exactly one-hot, or all 0 in HALT.
- Reset asserted mid-EXEC2: the next cycle is FETCH and no write enable is asserted in that cycle.
- eq is sampled only in the EXEC1 cycle.

Optional Feature:
- Macro: DECODE_STACK_GUARD_EN.
- Defined:
  - push_en is masked when stack_full; pop_en and the POP reg_wren are masked when stack_empty.
  - A masked attempt sets stack_err on the next edge. stack_err clears only on reset.
- Undefined:
  - push_en/pop_en/reg_wren are driven regardless of stack_full/stack_empty.
  - stack_err is tied to 0.

Test Plan:
- Reset, then ADR with D=2, NUM_REGS=4 -> cycle 1 fe=1 pc_cnten=1; cycle 2 e1=1 reg_wren=4'b0100; cycle 3 fe=1.
- LDA with D=3 -> e1 with reg_wren=0; then e2 with reg_wren=4'b1000; FETCH returns on the 4th cycle.
- JEQ: once with eq=1, once with eq=0 -> pc_sload=1 in EXEC1 for the first, 0 for the second. JNQ with eq=0 -> pc_sload=1.
- Stall held 3 cycles in EXEC1 of STA -> e1 stays 1; data_wren=0 during the stall; data_wren=1 in the first unstalled cycle.
- With DECODE_STACK_GUARD_EN defined, POP while stack_empty=1 -> pop_en=0, reg_wren=0, stack_err=1 on the next cycle. With the macro undefined -> pop_en=1, stack_err=0.
- STP -> halted=1 from the cycle after EXEC1, held for 10 cycles with instr_valid=1; reset -> fe=1, halted=0.
